pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the write-enables and synchronous flushes of the PC and the four inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Resolves four hazards: load-use, taken branch/jump, multi-cycle MUL/DIV, and data-memory wait states. Memory waits are guarded by a timeout counter.
- Sits beside the datapath; contains no datapath state of its own.

Parameters:
- REG_AW, 5, register-index width.
- TIMEOUT, 255, max consecutive memory-wait cycles before bus_err (must be ≥1 and < 2^CNT_W).
- CNT_W, 8, timeout counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  REG_AW  source indices of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the corresponding source is actually read.
- ex_rd  in  REG_AW  destination index of the instruction in EX.
- ex_is_load  in  1  EX holds a load.
- ex_is_mdu  in  1  EX holds a MUL/DIV.
- ex_br_taken  in  1  EX resolved a taken branch or jump.
- mem_req  in  1  MEM holds a valid load/store.
- mem_ready  in  1  data memory completes the access this cycle.
- mdu_done  in  1  one-cycle pulse: MDU result valid.
- mdu_start  out  1  one-cycle pulse launching the MDU.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register write-enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load NOP/bubble on next edge; overrides en inside the stage register.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- All outputs are combinational from state, counter and inputs.
- While rst_n=0: state=RUN, wait_cnt=0, and every output is 0.

States:
- RUN: normal operation.
- MDU_WAIT: MDU busy.
- MDU_HOLD: MDU result arrived while the pipeline was frozen.

Definitions:
- mem_freeze = mem_req & ~mem_ready.
- load_use = ex_is_load & ex_rd≠0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).

Priority (highest first):
1. mem_freeze: all five enables 0, all flushes 0, no state change except the counter.
2. MDU stall.
3. ex_br_taken.
4. load_use.
5. Normal advance: all enables 1.

Transitions and outputs by state:
- RUN & ex_is_mdu (no freeze):
  - mdu_start=1.
  - pc/if_id/id_ex en=0, ex_mem_flush=1, ex_mem_en=1, mem_wb_en=1.
  - Next state MDU_WAIT.
- MDU_WAIT & ~mdu_done: same stall pattern as above, but mdu_start=0.
- MDU_WAIT & mdu_done & ~mem_freeze:
  - All enables 1; EX/MEM captures the MDU result.
  - Next state RUN; no mdu_start for the departing instruction.
- MDU_WAIT & mdu_done & mem_freeze: next state MDU_HOLD (the result is held by the MDU).
- MDU_HOLD: freeze until ~mem_freeze, then all enables 1 and return to RUN.

Other hazards:
- ex_br_taken: all enables 1, if_id_flush=1, id_ex_flush=1 (two wrong-path instructions squashed).
- Branch and load_use in the same cycle: branch wins, no load-use stall.
- load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. Exactly one bubble per load-use.

Timeout:
- wait_cnt increments each mem_freeze cycle and clears on any cycle without mem_freeze.
- When wait_cnt==TIMEOUT-1 and mem_freeze:
  - bus_err=1.
  - Enables behave as if mem_ready=1.
  - wait_cnt clears.
- The trap is taken by downstream logic.

Constraints:
- mdu_done is never asserted in the same cycle as mdu_start.
- mdu_done is ignored in RUN.
- Reset mid-MDU returns to RUN; a later stray mdu_done is ignored.

Decomposition:
- Package pipe_pkg holds the state enum (RUN, MDU_WAIT, MDU_HOLD) and the NOP encoding constant used by the stage registers.
- One natural sub-module: hazard_detect (combinational load_use compare).
- The FSM and timeout counter stay in pipe_ctrl.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; then all enables 1. With ex_rd=0 -> no stall.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall cycle.
- MDU: ex_is_mdu=1, mdu_done 4 cycles later -> one mdu_start pulse, 4 stall cycles with ex_mem_flush=1, then one all-enable cycle; mdu_start never re-fires.
- mdu_done coinciding with mem_req=1, mem_ready=0 for 3 cycles -> MDU_HOLD; all enables 0 for 3 cycles, then advance.
- TIMEOUT=4, mem_ready held 0 -> enables 0 for cycles 1-3; cycle 4 bus_err=1 with enables 1; wait_cnt returns to 0.
- rst_n asserted during MDU_WAIT -> all outputs 0 immediately; after release state=RUN and a stray mdu_done produces no response.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control slice.
//   state_e   : sequencer states of pipe_ctrl.
//   ctrl_t    : bundle of the stage-register controls driven by pipe_ctrl.
//   NOP_INSTR : encoding loaded into a stage register when it is flushed.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN,       // normal operation
        MDU_WAIT,  // multi-cycle MUL/DIV in flight
        MDU_HOLD   // MDU result ready, pipeline still frozen by memory
    } state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic mdu_start;
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '0;

    localparam ctrl_t CTRL_ADVANCE = '{
        mdu_start: 1'b0, pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
        ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};

    // Front end held, bubble fed into MEM while the MDU works.
    localparam ctrl_t CTRL_MDU_STALL = '{
        mdu_start: 1'b0, pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0,
        ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};

    // Squash the two wrong-path instructions behind a taken branch.
    localparam ctrl_t CTRL_BRANCH = '{
        mdu_start: 1'b0, pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
        ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

    // Hold PC and IF/ID for one cycle, insert one bubble into ID/EX.
    localparam ctrl_t CTRL_LOAD_USE = '{
        mdu_start: 1'b0, pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1,
        ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the instruction in
// ID and a load in EX. A load to x0 never creates a dependency.
//   id_rs1/id_rs2           : source register indices in ID
//   id_rs1_used/id_rs2_used : the source is actually read
//   ex_rd, ex_is_load       : destination and load flag of EX
//   load_use                : ID must wait one cycle for the load data
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
// Drives the PC and IF/ID, ID/EX, EX/MEM, MEM/WB write-enables and flushes.
// Hazard priority: memory freeze > MDU stall > taken branch > load-use.
// A memory wait that reaches TIMEOUT cycles raises a one-cycle bus_err and
// lets the pipeline advance as if the access had completed.
//   Inputs : ID sources, EX destination/type, branch result, memory
//            handshake (mem_req/mem_ready), MDU completion (mdu_done).
//   Outputs: mdu_start, five stage enables, three flushes, bus_err.
//            All outputs are combinational and forced to 0 during reset.
// TIMEOUT must satisfy 1 <= TIMEOUT < 2**CNT_W.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_is_mdu,
    input  logic              ex_br_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              mdu_done,
    output logic              mdu_start,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             load_use;
    logic             mem_freeze;
    logic             timeout_hit;
    logic             freeze;
    ctrl_t            ctrl;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .load_use    (load_use)
    );

    assign mem_freeze  = mem_req && !mem_ready;
    assign timeout_hit = mem_freeze && (wait_cnt_q == WAIT_LAST);
    // On timeout everything behaves as though the access completed.
    assign freeze      = mem_freeze && !timeout_hit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // NOTE: every variable gets a default at the top of the combinational
    // block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = freeze ? wait_cnt_q + 1'b1 : '0;
        unique case (state_q)
            RUN:      if (ex_is_mdu && !freeze) state_d = MDU_WAIT;
            MDU_WAIT: if (mdu_done) state_d = freeze ? MDU_HOLD : RUN;
            MDU_HOLD: if (!freeze) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Reset is folded in here because the outputs are purely combinational
    // and must read 0 the moment rst_n drops, not at the next edge.
    always_comb begin
        ctrl = CTRL_ADVANCE;
        if (!rst_n) begin
            ctrl = CTRL_FREEZE;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_is_mdu) begin
                        ctrl           = CTRL_MDU_STALL;
                        ctrl.mdu_start = 1'b1;
                    end else if (ex_br_taken) begin
                        ctrl = CTRL_BRANCH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
                // On mdu_done EX/MEM captures the result: plain advance.
                MDU_WAIT: ctrl = mdu_done ? CTRL_ADVANCE : CTRL_MDU_STALL;
                MDU_HOLD: ctrl = CTRL_ADVANCE;
                default:  ctrl = CTRL_FREEZE;
            endcase
        end
    end

    assign mdu_start    = ctrl.mdu_start;
    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign bus_err      = rst_n && timeout_hit;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (TIMEOUT=4).
// Output vector order: {mdu_start, pc_en, if_id_en, id_ex_en, ex_mem_en,
//                       mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, bus_err}
module tb_pipe_ctrl;

    localparam int REG_AW  = 5;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    localparam logic [9:0] V_ZERO  = 10'b0_00000_000_0;
    localparam logic [9:0] V_NORM  = 10'b0_11111_000_0;
    localparam logic [9:0] V_LU    = 10'b0_00111_010_0;
    localparam logic [9:0] V_BR    = 10'b0_11111_110_0;
    localparam logic [9:0] V_START = 10'b1_00011_001_0;
    localparam logic [9:0] V_STALL = 10'b0_00011_001_0;
    localparam logic [9:0] V_TOUT  = 10'b0_11111_000_1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              ex_is_load, ex_is_mdu, ex_br_taken;
    logic              mem_req, mem_ready, mdu_done;
    logic              mdu_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic              if_id_flush, id_ex_flush, ex_mem_flush, bus_err;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_is_mdu    (ex_is_mdu),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mdu_done     (mdu_done),
        .mdu_start    (mdu_start),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] dut_vec();
        return {mdu_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, bus_err};
    endfunction

    task automatic check(input string name, input logic [9:0] actual, input logic [9:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    // Behavioural model: tracks "an MDU op is in flight", "an MDU result is
    // parked behind a memory stall" and the length of the current memory wait,
    // and derives every output from the hazard rules on each falling edge.
    bit m_busy = 1'b0;
    bit m_held = 1'b0;
    int m_wait = 0;

    always @(negedge clk) begin : model
        logic       stuck, expired, hold_all, lu;
        logic       st, pc, fi_en, dx_en, em_en, mw_en, fl_if, fl_id, fl_ex;
        logic [9:0] exp_v;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_held = 1'b0;
            m_wait = 0;
            check("model_reset", dut_vec(), V_ZERO);
        end else begin
            stuck    = mem_req && !mem_ready;
            expired  = stuck && (m_wait == TIMEOUT - 1);
            hold_all = stuck && !expired;
            lu = ex_is_load && (ex_rd != 0) &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
            {st, pc, fi_en, dx_en, em_en, mw_en, fl_if, fl_id, fl_ex} = 9'b0_11111_000;
            if (hold_all) begin
                {st, pc, fi_en, dx_en, em_en, mw_en, fl_if, fl_id, fl_ex} = '0;
            end else if (m_held || (m_busy && mdu_done)) begin
                // result delivered: plain advance
            end else if (m_busy || ex_is_mdu) begin
                st = !m_busy;
                {pc, fi_en, dx_en} = 3'b000;
                fl_ex = 1'b1;
            end else if (ex_br_taken) begin
                {fl_if, fl_id} = 2'b11;
            end else if (lu) begin
                {pc, fi_en} = 2'b00;
                fl_id = 1'b1;
            end
            exp_v = {st, pc, fi_en, dx_en, em_en, mw_en, fl_if, fl_id, fl_ex, expired};
            check("model", dut_vec(), exp_v);
            m_wait = hold_all ? m_wait + 1 : 0;
            if (m_held) begin
                m_held = hold_all;
            end else if (m_busy) begin
                if (mdu_done) begin
                    m_busy = 1'b0;
                    m_held = hold_all;
                end
            end else if (ex_is_mdu && !hold_all) begin
                m_busy = 1'b1;
            end
        end
    end

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_is_load = 1'b0; ex_is_mdu = 1'b0; ex_br_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; mdu_done = 1'b0;
    endtask

    // Inputs change just after the rising edge; compare point is the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        at_sample();
        check("reset_outputs", dut_vec(), V_ZERO);

        next_cycle(); rst_n = 1'b1;
        at_sample(); check("idle_advance", dut_vec(), V_NORM);

        // Load-use on rs1: exactly one bubble.
        next_cycle(); ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        at_sample(); check("load_use_rs1", dut_vec(), V_LU);
        next_cycle();
        at_sample(); check("after_load_use", dut_vec(), V_NORM);

        // Load-use on rs2; then matching rs2 that is not read.
        next_cycle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        at_sample(); check("load_use_rs2", dut_vec(), V_LU);
        next_cycle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
        at_sample(); check("rs2_unused", dut_vec(), V_NORM);

        // Load to x0 never stalls.
        next_cycle(); ex_is_load = 1'b1; id_rs1_used = 1'b1;
        at_sample(); check("load_x0", dut_vec(), V_NORM);

        // Branch and load-use together: branch wins.
        next_cycle(); ex_br_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
        at_sample(); check("branch_over_lu", dut_vec(), V_BR);
        next_cycle();
        at_sample(); check("after_branch", dut_vec(), V_NORM);

        // MDU: start, four stall cycles, done on the fifth.
        next_cycle(); ex_is_mdu = 1'b1;
        at_sample(); check("mdu_start", dut_vec(), V_START);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); ex_is_mdu = 1'b1;
            at_sample(); check("mdu_stall", dut_vec(), V_STALL);
        end
        next_cycle(); ex_is_mdu = 1'b1; mdu_done = 1'b1;
        at_sample(); check("mdu_done_adv", dut_vec(), V_NORM);
        next_cycle();
        at_sample(); check("mdu_no_refire", dut_vec(), V_NORM);

        // MDU result arriving during a 3-cycle memory stall.
        next_cycle(); ex_is_mdu = 1'b1;
        at_sample(); check("hold_start", dut_vec(), V_START);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); ex_is_mdu = 1'b1; mem_req = 1'b1; mdu_done = (i == 0);
            at_sample(); check("hold_freeze", dut_vec(), V_ZERO);
        end
        next_cycle(); ex_is_mdu = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
        at_sample(); check("hold_release", dut_vec(), V_NORM);
        next_cycle();
        at_sample(); check("hold_back_run", dut_vec(), V_NORM);

        // Memory timeout: three frozen cycles, bus_err on the fourth.
        for (int i = 1; i <= 3; i++) begin
            next_cycle(); mem_req = 1'b1;
            at_sample(); check("timeout_wait", dut_vec(), V_ZERO);
        end
        next_cycle(); mem_req = 1'b1;
        at_sample(); check("timeout_err", dut_vec(), V_TOUT);
        next_cycle(); mem_req = 1'b1;
        at_sample(); check("timeout_cnt_clr", dut_vec(), V_ZERO);
        next_cycle(); mem_req = 1'b1; mem_ready = 1'b1;
        at_sample(); check("mem_done", dut_vec(), V_NORM);

        // Reset in MDU_WAIT, then a stray mdu_done.
        next_cycle(); ex_is_mdu = 1'b1;
        at_sample(); check("rst_mdu_start", dut_vec(), V_START);
        next_cycle(); ex_is_mdu = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_vec(), V_ZERO);
        at_sample();
        next_cycle(); rst_n = 1'b1; mdu_done = 1'b1;
        at_sample(); check("stray_done", dut_vec(), V_NORM);
        next_cycle();
        at_sample(); check("post_reset_run", dut_vec(), V_NORM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
